serial_audio_encoder: RTL and testbench

Master-mode serial audio transmitter: the counterpart of `serial_audio_decoder`. It accepts a valid/ready stream of alternating left/right PCM samples and drives `sclk`, `lrclk` and `sdout` in I2S or left-justified format. `sclk` and `lrclk` are derived by division from the single system clock. It sits after the echo effect, in place of or next to the S/PDIF encoder, and drives an external DAC.

---
 rtl/serial_audio_pkg.sv | 17 +
 rtl/serial_audio_encoder_if.sv | 23 ++
 rtl/serial_audio_clock_gen.sv | 48 ++++
 rtl/serial_audio_encoder.sv | 129 ++++++++++++
 tb/tb_serial_audio_encoder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_audio_pkg.sv
// Shared channel and format encodings for the serial audio encoder and decoder.
package serial_audio_pkg;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  // Values of the is_i2s select
  localparam logic LJ  = 1'b0;
  localparam logic I2S = 1'b1;

  function automatic chan_e chan_flip(input chan_e c);
    return (c == LEFT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/serial_audio_encoder_if.sv
// PCM sample stream into the serial audio encoder (valid/ready handshake).
interface serial_audio_encoder_if #(
  parameter int audio_width = 16
) ();
  logic                          i_valid;
  logic                          i_ready;
  logic                          i_is_left;
  logic signed [audio_width-1:0] i_audio;

  modport master (
    output i_valid,
    output i_is_left,
    output i_audio,
    input  i_ready
  );

  modport slave (
    input  i_valid,
    input  i_is_left,
    input  i_audio,
    output i_ready
  );
endinterface

// File: rtl/serial_audio_clock_gen.sv
// Bit/word clock generation: divides clk down to sclk, produces the falling
// strobe, tracks the bit position within a slot and the current channel.
module serial_audio_clock_gen
  import serial_audio_pkg::*;
#(
  parameter int bits_per_channel = 32,
  parameter int sclk_half        = 2
) (
  input  logic  clk,
  input  logic  nreset,
  output logic  sclk,
  output logic  fall,
  output logic  slot_start,
  output chan_e chan,
  output chan_e next_chan
);

  localparam int DIV_W = (sclk_half > 1) ? $clog2(sclk_half) : 1;
  localparam int BIT_W = $clog2(bits_per_channel);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(sclk_half - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(bits_per_channel - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             div_wrap;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign fall       = div_wrap && sclk;
  assign slot_start = fall && (bit_cnt == BIT_LAST);
  assign next_chan  = chan_flip(chan);

  // Divider, sclk toggle, slot bit counter and channel; bit_cnt resets to the
  // last slot bit so the first falling strobe opens a left slot.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_cnt <= BIT_LAST;
      chan    <= RIGHT;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) sclk <= ~sclk;
      if (fall) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      if (slot_start) chan <= next_chan;
    end
  end

endmodule

// File: rtl/serial_audio_encoder.sv
// Master-mode I2S / left-justified serial audio transmitter.
// Optional build macro SERIAL_AUDIO_ENCODER_REPEAT_EN: on underrun, repeat the
// last word sent on that channel instead of sending silence.
module serial_audio_encoder
  import serial_audio_pkg::*;
#(
  parameter int audio_width      = 16,
  parameter int bits_per_channel = 32,
  parameter int sclk_half        = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   is_i2s,
  input  logic                   lrclk_polarity,
  serial_audio_encoder_if.slave  pcm,
  output logic                   sclk,
  output logic                   lrclk,
  output logic                   sdout,
  output logic                   is_underrun,
  output logic                   is_error
);

  localparam int PAD_W = bits_per_channel - audio_width;

  chan_e chan;
  chan_e next_chan;
  chan_e expected;
  chan_e in_chan;
  logic  fall;
  logic  slot_start;
  logic  nxt_idx;
  logic  exp_idx;
  logic  accept;
  logic  store;
  logic  mismatch;

  logic [1:0]                      full;
  logic [1:0]                      full_nxt;
  logic signed [audio_width-1:0]   hold [2];
  logic signed [audio_width-1:0]   fill_sample;
  logic signed [audio_width-1:0]   load_sample;
  logic [bits_per_channel-1:0]     load_word;
  logic [bits_per_channel-1:0]     shift_p0;

  serial_audio_clock_gen #(
    .bits_per_channel (bits_per_channel),
    .sclk_half        (sclk_half)
  ) u_clock_gen (
    .clk        (clk),
    .nreset     (nreset),
    .sclk       (sclk),
    .fall       (fall),
    .slot_start (slot_start),
    .chan       (chan),
    .next_chan  (next_chan)
  );

  assign lrclk   = (chan == RIGHT) ^ lrclk_polarity;
  assign nxt_idx = next_chan;
  assign exp_idx = expected;
  assign in_chan = pcm.i_is_left ? LEFT : RIGHT;

  assign pcm.i_ready = !full[exp_idx];
  assign accept      = pcm.i_valid && pcm.i_ready;
  assign store       = accept && (in_chan == expected);
  assign mismatch    = accept && (in_chan != expected);

  // The slot start sees the holding register as it was before this cycle's
  // accept, so a same-cycle sample waits for the channel's next slot.
  assign load_sample = full[nxt_idx] ? hold[nxt_idx] : fill_sample;
  assign load_word   = {load_sample, {PAD_W{1'b0}}};

`ifdef SERIAL_AUDIO_ENCODER_REPEAT_EN
  logic signed [audio_width-1:0] last_sample [2];

  // Remember the word each channel last carried, used as underrun fill.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_sample[0] <= '0;
      last_sample[1] <= '0;
    end else if (slot_start) begin
      last_sample[nxt_idx] <= load_sample;
    end
  end

  assign fill_sample = last_sample[nxt_idx];
`else
  assign fill_sample = '0;
`endif

  // Full flags: a slot start empties its channel, a stored sample fills one.
  always_comb begin
    full_nxt = full;
    if (slot_start) full_nxt[nxt_idx] = 1'b0;
    if (store)      full_nxt[exp_idx] = 1'b1;
  end

  // Handshake control, status pulses and the serial data output.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      expected    <= LEFT;
      full        <= 2'b00;
      sdout       <= 1'b0;
      is_underrun <= 1'b0;
      is_error    <= 1'b0;
    end else begin
      full        <= full_nxt;
      is_underrun <= slot_start && !full[nxt_idx];
      is_error    <= mismatch;
      if (store) expected <= chan_flip(expected);
      if (slot_start) begin
        sdout <= (is_i2s == I2S) ? 1'b0 : load_word[bits_per_channel-1];
      end else if (fall) begin
        sdout <= shift_p0[bits_per_channel-1];
      end
    end
  end

  // Sample holding registers and the slot shift register (data only).
  always_ff @(posedge clk) begin
    if (store) hold[exp_idx] <= pcm.i_audio;
    if (slot_start) begin
      shift_p0 <= (is_i2s == I2S) ? load_word : (load_word << 1);
    end else if (fall) begin
      shift_p0 <= shift_p0 << 1;
    end
  end

endmodule

// File: tb/tb_serial_audio_encoder.sv
// Self-checking bench for serial_audio_encoder against a slot-arithmetic model.
module tb_serial_audio_encoder;

  localparam int W = 16;
  localparam int B = 32;
  localparam int H = 2;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic is_i2s = 1'b0;
  logic lrclk_polarity = 1'b0;
  logic sclk, lrclk, sdout, is_underrun, is_error;

  serial_audio_encoder_if #(.audio_width(W)) bus ();

  serial_audio_encoder #(
    .audio_width      (W),
    .bits_per_channel (B),
    .sclk_half        (H)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .is_i2s         (is_i2s),
    .lrclk_polarity (lrclk_polarity),
    .pcm            (bus),
    .sclk           (sclk),
    .lrclk          (lrclk),
    .sdout          (sdout),
    .is_underrun    (is_underrun),
    .is_error       (is_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state (channel 0 = left, 1 = right)
  int          m_t;
  int          m_k;
  logic [1:0]  m_full;
  logic [15:0] m_hold [2];
  logic [15:0] m_last [2];
  logic        m_exp;
  logic        m_chan;
  logic [31:0] m_word;
  logic        m_sclk, m_sdout, m_underrun, m_error, m_i2s, m_pol;

  // Stimulus: queue of {is_left, sample}
  logic [16:0] q[$];
  bit          rand_fill, gap_en, err_en;
  logic        gen_exp;
  bit          prev_sclk;
  bit          cap_bit[$];
  bit          cap_lr[$];
  int          cap_cyc[$];
  int          und_cnt, err_cnt;

  task automatic model_reset(input logic i2s, input logic pol);
    m_t = 0; m_k = B - 1; m_full = 2'b00; m_exp = 1'b0; m_chan = 1'b1;
    m_hold[0] = '0; m_hold[1] = '0; m_last[0] = '0; m_last[1] = '0;
    m_word = '0; m_sclk = 0; m_sdout = 0; m_underrun = 0; m_error = 0;
    m_i2s = i2s; m_pol = pol;
  endtask

  task automatic model_edge();
    logic        ready_pre;
    logic        ch;
    logic [15:0] smp;
    int          n;
    m_t++;
    ready_pre  = !m_full[m_exp];
    m_underrun = 1'b0;
    m_error    = 1'b0;
    m_sclk     = ((m_t / H) % 2) == 1;
    if (m_t % (2 * H) == 0) begin
      n   = m_t / (2 * H) - 1;
      m_k = n % B;
      if (m_k == 0) begin
        ch = ((n / B) % 2) == 1;
        m_underrun = !m_full[ch];
`ifdef SERIAL_AUDIO_ENCODER_REPEAT_EN
        smp = m_full[ch] ? m_hold[ch] : m_last[ch];
`else
        smp = m_full[ch] ? m_hold[ch] : 16'h0000;
`endif
        m_last[ch] = smp;
        m_full[ch] = 1'b0;
        m_chan     = ch;
        m_word     = {smp, 16'h0000};
      end
      if (m_i2s) m_sdout = (m_k == 0) ? 1'b0 : m_word[B - m_k];
      else       m_sdout = m_word[B - 1 - m_k];
    end
    if (bus.i_valid && ready_pre) begin
      if (bus.i_is_left == (m_exp == 1'b0)) begin
        m_hold[m_exp] = bus.i_audio;
        m_full[m_exp] = 1'b1;
        m_exp = !m_exp;
      end else begin
        m_error = 1'b1;
      end
      void'(q.pop_front());
    end
  endtask

  task automatic refill();
    bit   bad;
    logic lft;
    while (q.size() < 2) begin
      bad = err_en && ($urandom_range(7) == 0);
      lft = bad ? (gen_exp == 1'b1) : (gen_exp == 1'b0);
      q.push_back({lft, 16'($urandom)});
      if (!bad) gen_exp = !gen_exp;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_eq("sclk", sclk, m_sclk);
    check_eq("lrclk", lrclk, m_chan ^ m_pol);
    check_eq("sdout", sdout, m_sdout);
    check_eq("underrun", is_underrun, m_underrun);
    check_eq("error", is_error, m_error);
    check_eq("ready", bus.i_ready, !m_full[m_exp]);
    if (is_underrun) und_cnt++;
    if (is_error) err_cnt++;
    if (prev_sclk && !sclk) begin
      cap_bit.push_back(sdout);
      cap_lr.push_back(lrclk);
      cap_cyc.push_back(m_t);
    end
    prev_sclk = sclk;
    if (rand_fill) refill();
    if (q.size() > 0) begin
      bus.i_valid   = !gap_en || ($urandom_range(2) != 0);
      bus.i_is_left = q[0][16];
      bus.i_audio   = q[0][15:0];
    end else begin
      bus.i_valid = 1'b0;
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset(input logic i2s, input logic pol);
    @(negedge clk);
    nreset = 1'b0;
    is_i2s = i2s;
    lrclk_polarity = pol;
    bus.i_valid = 1'b0;
    #1;
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_sdout", sdout, 1'b0);
    check_eq("rst_underrun", is_underrun, 1'b0);
    check_eq("rst_error", is_error, 1'b0);
    check_eq("rst_ready", bus.i_ready, 1'b1);
    check_eq("rst_lrclk", lrclk, 1'b1 ^ pol);
    q.delete(); cap_bit.delete(); cap_lr.delete(); cap_cyc.delete();
    rand_fill = 0; gap_en = 0; err_en = 0; gen_exp = 1'b0;
    prev_sclk = 0; und_cnt = 0; err_cnt = 0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    model_reset(i2s, pol);
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [15:0] cap_word(input int start);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = cap_bit[start+i];
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    logic pad;
    bus.i_valid = 1'b0;
    bus.i_is_left = 1'b0;
    bus.i_audio = '0;

    // I2S, polarity 0, directed samples
    do_reset(1'b1, 1'b0);
    q.push_back({1'b1, 16'hA5F0});
    q.push_back({1'b0, 16'h0F0F});
    repeat (2 * 256 + 8) step();
    check_eq("i2s_nfalls", cap_bit.size() >= 65, 1'b1);
    if (cap_bit.size() >= 65) begin
      check_eq("i2s_lead", cap_bit[0], 1'b0);
      check_eq("i2s_left", cap_word(1), 16'hA5F0);
      pad = 1'b0;
      for (int i = 17; i < 32; i++) pad = pad | cap_bit[i];
      check_eq("i2s_pad", pad, 1'b0);
      check_eq("i2s_right", cap_word(33), 16'h0F0F);
      check_eq("i2s_lr_left", cap_lr[0], 1'b0);
      check_eq("i2s_lr_right", cap_lr[32], 1'b1);
      check_eq("first_fall", cap_cyc[0], 4);
      check_eq("frame_len", cap_cyc[64] - cap_cyc[0], 256);
    end

    // Left-justified, polarity 1
    do_reset(1'b0, 1'b1);
    q.push_back({1'b1, 16'hA5F0});
    q.push_back({1'b0, 16'h0F0F});
    repeat (300) step();
    check_eq("lj_nfalls", cap_bit.size() >= 49, 1'b1);
    if (cap_bit.size() >= 49) begin
      check_eq("lj_left", cap_word(0), 16'hA5F0);
      check_eq("lj_right", cap_word(32), 16'h0F0F);
      check_eq("lj_lr_left", cap_lr[0], 1'b1);
    end

    // No input: one underrun per slot start, then a single left sample
    do_reset(1'b1, 1'b0);
    repeat (512) step();
    check_eq("underrun_cnt", und_cnt, 4);
    q.push_back({1'b1, 16'h1234});
    repeat (600) step();

    // Wrong channel first: discarded with one error pulse
    do_reset(1'b1, 1'b0);
    q.push_back({1'b0, 16'h1111});
    q.push_back({1'b1, 16'h2222});
    q.push_back({1'b0, 16'h3333});
    repeat (300) step();
    check_eq("error_cnt", err_cnt, 1);

    // Continuous valid, random data, 8 frames
    do_reset(1'b0, 1'b0);
    rand_fill = 1;
    repeat (8 * 256) step();

    // Random gaps and occasional wrong-channel samples
    do_reset(1'b1, 1'b1);
    rand_fill = 1; gap_en = 1; err_en = 1;
    repeat (1024) step();

    // Reset in the middle of left slot bit 10
    do_reset(1'b1, 1'b0);
    rand_fill = 1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (m_chan == 1'b0 && m_k == 10 && m_t > 4) found = 1;
    end
    check_eq("reach_bit10", found, 1'b1);
    do_reset(1'b1, 1'b0);
    repeat (12) step();
    check_eq("fall_seen", cap_cyc.size() > 0, 1'b1);
    if (cap_cyc.size() > 0) check_eq("restart_fall", cap_cyc[0], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
